// File: rtl/ext_arb_pkg.sv
// ----------------------------------------------------------------------------
// ext_arb_pkg: shared types and widths for the extend-unit arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ext_arb_pkg;
   localparam int IMM_W  = 16;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXT  = 2'd1,
      RESP = 2'd2
   } state_e;
endpackage

`default_nettype wire

// File: rtl/ext_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// ext_rr_arbiter_rr_pick: combinational round-robin search from a pointer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ext_rr_arbiter_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             any_o
);
   logic [ID_W:0] cand;
   logic          found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         // Wrap the candidate index back into 0..N_REQ-1.
         cand = {1'b0, ptr_i} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ))
            cand = cand - (ID_W+1)'(N_REQ);
         if (!found && valid_i[cand[ID_W-1:0]]) begin
            found                   = 1'b1;
            gnt_o[cand[ID_W-1:0]]   = 1'b1;
            idx_o                   = cand[ID_W-1:0];
         end
      end
      any_o = found;
   end
endmodule

`default_nettype wire

// File: rtl/ext_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ext_rr_arbiter: round-robin sharing of one immediate-extend unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ext_rr_arbiter
   import ext_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid_i,
   output logic [N_REQ-1:0]       req_ready_o,
   input  logic [IMM_W*N_REQ-1:0] req_imm_i,
   input  logic [N_REQ-1:0]       req_sext_i,
   output logic [IMM_W-1:0]       ext_a_o,
   output logic                   ext_sext_o,
   input  logic [DATA_W-1:0]      ext_b_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DATA_W-1:0]      rsp_data_o,
   output logic [ID_W-1:0]        rsp_id_o,
   output logic [15:0]            xfer_cnt_o
);
   state_e               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q;
   logic [IMM_W-1:0]     a_q;
   logic                 sext_q;
   logic [ID_W-1:0]      id_q;
   logic                 rsp_valid_q;
   logic [DATA_W-1:0]    rsp_data_q;
   logic [ID_W-1:0]      rsp_id_q;
   logic [15:0]          cnt_q;

   logic [N_REQ-1:0]     pick_gnt;
   logic [ID_W-1:0]      pick_idx;
   logic                 pick_any;
   logic [IMM_W-1:0]     win_imm;
   logic                 win_sext;
   logic [ID_W-1:0]      ptr_next;

   ext_rr_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .valid_i (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   always_comb begin
      win_imm  = '0;
      win_sext = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_gnt[i]) begin
            win_imm  = req_imm_i[i*IMM_W +: IMM_W];
            win_sext = req_sext_i[i];
         end
      end
   end

   assign ptr_next = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      case (state_q)
         IDLE: begin
            req_ready_o = pick_gnt;
            if (pick_any) state_d = EXT;
         end
         EXT:  state_d = RESP;
         RESP: if (rsp_valid_q && rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand, response and pointer registers; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         a_q         <= '0;
         sext_q      <= 1'b0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: if (pick_any) begin
               a_q    <= win_imm;
               sext_q <= win_sext;
               id_q   <= pick_idx;
            end
            EXT: begin
               rsp_data_q  <= ext_b_i;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
            end
            RESP: if (rsp_valid_q && rsp_ready_i) begin
               rsp_valid_q <= 1'b0;
               cnt_q       <= cnt_q + 16'd1;
               rr_ptr_q    <= ptr_next;
            end
            default: ;
         endcase
      end
   end

   assign ext_a_o     = a_q;
   assign ext_sext_o  = sext_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_id_o    = rsp_id_q;
   assign xfer_cnt_o  = cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_ext_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ext_rr_arbiter: directed self-checking bench for ext_rr_arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ext_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_imm;
   logic [3:0]  req_sext;
   logic [15:0] ext_a;
   logic        ext_sext;
   logic [31:0] ext_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_id;
   logic [15:0] xfer_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   // The external extend unit.
   assign ext_b = ext_sext ? {{16{ext_a[15]}}, ext_a} : {16'h0000, ext_a};

   ext_rr_arbiter #(.N_REQ(4), .ID_W(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_imm_i   (req_imm),
      .req_sext_i  (req_sext),
      .ext_a_o     (ext_a),
      .ext_sext_o  (ext_sext),
      .ext_b_i     (ext_b),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_id_o    (rsp_id),
      .xfer_cnt_o  (xfer_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input int idx, input logic [15:0] imm, input logic sext,
                         input logic [31:0] exp_data);
      req_imm[idx*16 +: 16] = imm;
      req_sext[idx]         = sext;
      req_valid             = 4'(1 << idx);
      rsp_ready             = 1'b0;
      #1;
      check("grant_onehot", {28'h0, req_ready}, 32'(1 << idx));
      tick();
      req_valid = 4'h0;
      check("ext_a", {16'h0, ext_a}, {16'h0, imm});
      check("ready_in_ext", {28'h0, req_ready}, 32'h0);
      check("valid_in_ext", {31'h0, rsp_valid}, 32'h0);
      tick();
      check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("rsp_data", rsp_data, exp_data);
      check("rsp_id", {30'h0, rsp_id}, 32'(idx));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
      check("valid_after_hs", {31'h0, rsp_valid}, 32'h0);
      check("xfer_cnt", {16'h0, xfer_cnt}, 32'(exp_cnt));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_cnt = 0;
   endtask

   initial begin
      logic [1:0]  rr_ids [5];
      logic [31:0] rr_dat [4];
      logic [1:0]  sk_ids [4];
      int n, cyc, last;

      rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rr_dat = '{32'h00007FFF, 32'hFFFF8001, 32'h00000002, 32'hFFFFC003};
      sk_ids = '{2'd3, 2'd1, 2'd3, 2'd1};

      req_valid = 4'h0;
      req_imm   = 64'h0;
      req_sext  = 4'h0;
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      #12;
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst_xfer_cnt", {16'h0, xfer_cnt}, 32'h0);
      check("rst_req_ready", {28'h0, req_ready}, 32'h0);
      check("rst_ext_a", {16'h0, ext_a}, 32'h0);
      check("rst_rsp_data", rsp_data, 32'h0);
      apply_reset();

      // Sign-extend with 10 cycles of backpressure.
      req_imm[15:0] = 16'h8000;
      req_sext[0]   = 1'b1;
      req_valid     = 4'b0001;
      #1;
      check("se_grant", {28'h0, req_ready}, 32'h1);
      tick();
      req_valid = 4'b0000;
      check("se_ext_sext", {31'h0, ext_sext}, 32'h1);
      tick();
      check("se_valid_lat2", {31'h0, rsp_valid}, 32'h1);
      check("se_data", rsp_data, 32'hFFFF8000);
      req_valid = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid", {31'h0, rsp_valid}, 32'h1);
         check("bp_data", rsp_data, 32'hFFFF8000);
         check("bp_id", {30'h0, rsp_id}, 32'h0);
         check("bp_ready", {28'h0, req_ready}, 32'h0);
         check("bp_cnt", {16'h0, xfer_cnt}, 32'h0);
      end
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_cnt_inc", {16'h0, xfer_cnt}, 32'h1);
      tick();
      check("bp_cnt_once", {16'h0, xfer_cnt}, 32'h1);
      exp_cnt = 1;

      // Zero/sign extend corners.
      do_req(0, 16'h8000, 1'b0, 32'h00008000);
      do_req(0, 16'hFFFF, 1'b0, 32'h0000FFFF);
      do_req(0, 16'hFFFF, 1'b1, 32'hFFFFFFFF);
      do_req(2, 16'h7123, 1'b1, 32'h00007123);

      // Round-robin across all four requesters.
      apply_reset();
      req_imm   = {16'hC003, 16'h0002, 16'h8001, 16'h7FFF};
      req_sext  = 4'b1010;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      n = 0; cyc = 0; last = 0;
      while (n < 5 && cyc < 40) begin
         tick();
         cyc++;
         if (rsp_valid) begin
            check("rr_id", {30'h0, rsp_id}, {30'h0, rr_ids[n]});
            check("rr_data", rsp_data, rr_dat[rr_ids[n]]);
            if (n == 0) check("rr_first_lat", 32'(cyc), 32'd2);
            else        check("rr_gap", 32'(cyc - last), 32'd3);
            last = cyc;
            n++;
         end
      end
      if (n < 5) check("rr_timeout", 32'(n), 32'd5);
      req_valid = 4'h0;
      tick();
      check("rr_xfer_cnt", {16'h0, xfer_cnt}, 32'd5);
      rsp_ready = 1'b0;
      exp_cnt = 5;

      // Move pointer to 2, then only req1/req3 valid: 3,1,3,1.
      do_req(1, 16'h8001, 1'b1, 32'hFFFF8001);
      req_valid = 4'b1010;
      rsp_ready = 1'b1;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 40) begin
         tick();
         cyc++;
         if (rsp_valid) begin
            check("skip_id", {30'h0, rsp_id}, {30'h0, sk_ids[n]});
            n++;
         end
      end
      if (n < 4) check("skip_timeout", 32'(n), 32'd4);
      req_valid = 4'h0;
      tick();
      rsp_ready = 1'b0;
      exp_cnt += 4;
      check("skip_xfer_cnt", {16'h0, xfer_cnt}, 32'(exp_cnt));

      // Reset while in EXT; pointer is 2 here so req3 is granted first.
      req_valid = 4'b1010;
      #1;
      check("mid_grant3", {28'h0, req_ready}, 32'h8);
      tick();
      check("mid_ext_a", {16'h0, ext_a}, 32'h0000C003);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
      check("mid_rst_cnt", {16'h0, xfer_cnt}, 32'h0);
      check("mid_rst_ext_a", {16'h0, ext_a}, 32'h0);
      tick();
      check("mid_rst_hold", {31'h0, rsp_valid}, 32'h0);
      rst_n = 1'b1;
      #1;
      check("post_rst_grant", {28'h0, req_ready}, 32'h2);
      tick();
      req_valid = 4'h0;
      tick();
      check("post_rst_id", {30'h0, rsp_id}, 32'h1);
      check("post_rst_data", rsp_data, 32'hFFFF8001);
      rsp_ready = 1'b1;
      tick();
      check("post_rst_cnt", {16'h0, xfer_cnt}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/ext_rr_arbiter.md
Name: ext_rr_arbiter

Overview:
Shares the single immediate-extend unit (16-bit in, sext select, 32-bit out) among N_REQ requesters, such as decode, branch-offset and load/store address paths.
Arbitrates round-robin, registers the winning operand, drives the extend unit, and returns the 32-bit result with the requester ID over a valid/ready response channel.
Sits between the requesters and the one extend instance; it is the only driver of that instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, response ID width; must satisfy 2**ID_W >= N_REQ

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero
req_imm  in  16*N_REQ  packed immediates; requester i uses bits [16*i+15:16*i]
req_sext  in  N_REQ  per-requester extend mode: 1 = sign-extend, 0 = zero-extend
ext_a  out  16  operand to the extend unit
ext_sext  out  1  mode to the extend unit
ext_b  in  32  combinational result from the extend unit
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer ready
rsp_data  out  32  extended result
rsp_id  out  ID_W  index of the requester served
xfer_cnt  out  16  count of completed responses

Behaviour:
- Reset (asynchronous, rst_n=0) forces the following:
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, xfer_cnt=0
  - ext_a=0, ext_sext=0 (operand registers cleared), req_ready=0
- FSM states: IDLE, EXT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
  - req_ready[winner]=1 combinationally in this cycle only; the handshake completes on this edge.
  - On the edge, latch req_imm[winner], req_sext[winner] and winner into the operand/ID registers, then go to EXT.
  - No valid request: stay in IDLE with req_ready all zero.
- EXT:
  - ext_a and ext_sext come from the operand registers.
  - On the edge, rsp_data<=ext_b, rsp_id<=latched ID, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_data, rsp_id and rsp_valid are held stable while rsp_ready=0.
  - On an edge with rsp_valid and rsp_ready both 1: rsp_valid<=0, xfer_cnt<=xfer_cnt+1 (wraps 0xFFFF->0), rr_ptr<=(latched ID+1) mod N_REQ, go to IDLE.
- Latency:
  - Grant cycle to rsp_valid high = 2 cycles.
  - Best-case throughput is 1 response per 3 cycles.
- req_ready is 0 in EXT and RESP. Requests arriving then wait, and requesters must hold req_valid and their operands.
- Round-robin fairness: a continuously requesting input is served within N_REQ grants.
- rr_ptr advances only on response handshake, never on grant alone.
- Invalid requesters are skipped.
- An ID >= N_REQ is never produced.
- Extend contract, checked in EXT:
  - sext=1: ext_b = {16{a[15]}, a}
  - sext=0: ext_b = {16'h0, a}
- Reset mid-operation (any state) aborts the transaction:
  - The response is dropped, not replayed.
  - xfer_cnt is not incremented.
- A requester dropping req_valid while not granted is legal and causes no side effect.

Decomposition:
- Shared package ext_arb_pkg holds:
  - the state encoding constants (IDLE=2'd0, EXT=2'd1, RESP=2'd2)
  - IMM_W=16 and DATA_W=32
- Natural sub-module: rr_pick, purely combinational. It takes req_valid and rr_ptr and returns a one-hot grant plus the winner index.
- The extend unit is instantiated at the level above and connected through the ext_* ports; it is not instantiated inside this block.

Test Plan:
- Sign-extend: req0 imm=16'h8000, sext=1 -> rsp_data=32'hFFFF8000, rsp_id=0, rsp_valid 2 cycles after the grant.
- Zero-extend: req0 imm=16'h8000, sext=0 -> 32'h00008000. Also imm=16'hFFFF, sext=0 -> 32'h0000FFFF; sext=1 -> 32'hFFFFFFFF.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0, each response 3 cycles apart, xfer_cnt=5.
- Backpressure: rsp_ready=0 for 10 cycles while in RESP -> rsp_data and rsp_id stable, req_ready all 0, xfer_cnt unchanged. Then rsp_ready=1 -> exactly one increment.
- Skip and wrap: only req1 and req3 valid, rr_ptr=2 -> order 3,1,3.
- Reset mid-operation: assert rst_n=0 in EXT -> rsp_valid=0 and xfer_cnt=0 immediately. After release, the next grant goes to the lowest-index valid requester (rr_ptr=0).
